video_fb_reader_core: RTL and testbench
=======================================

// Module: video_fb_reader_core
// PURPOSE
//  Frame-buffer reader: scans a 640x480 image out of the external SRAM in raster order.
//  Emits it as a daisy-chain pixel source (vga_fc_t + vld/rdy + rgb) that replaces the frame counter / bar core head.
//  Read-side counterpart of the SRAM frame-buffer writer; lets software-drawn images feed the video core chain.
// PARAMETERS
//  RGB_SIZE    12    pixel width; pixel = sram_dq_read[RGB_SIZE-1:0]
//  SRAM_AW     18    SRAM word-address width
//  SRAM_DW     16    SRAM data width (RGB_SIZE <= SRAM_DW)
//  H_DISPLAY   640   visible pixels per line
//  V_DISPLAY   480   visible lines per frame
//  READ_WAIT   2     cycles ce_n/oe_n held low per read (>=1); data sampled on the last one
//  FIFO_DEPTH  4     output skid FIFO depth, power of 2, >=2
// PORTS
//  clk            in   1          system clock
//  rst            in   1          asynchronous, active-high reset
//  avs_address    in   1          0=CTRL, 1=BASE
//  avs_write      in   1          register write strobe
//  avs_writedata  in   32         CTRL[0]=enable; BASE[SRAM_AW-1:0]=frame base word address
//  sram_ce_n      out  1          chip enable, active low
//  sram_oe_n      out  1          output enable, active low
//  sram_we_n      out  1          tied 1 (read-only)
//  sram_be_n      out  SRAM_DW/8  all 0 during reads, all 1 otherwise
//  sram_addr      out  SRAM_AW    read address
//  sram_dq_en     out  1          tied 0 (never drives dq)
//  sram_dq_read   in   SRAM_DW    read data
//  snk_fc         out  vga_fc_t   hc/vc of output pixel; frame_start=1 only at (0,0)
//  snk_vld        out  1          output pixel valid
//  snk_rgb        out  RGB_SIZE   output pixel
//  snk_rdy        in   1          downstream ready
// BEHAVIOUR
//  Reset: ce_n=oe_n=1, be_n=all 1, addr=0, snk_vld=0, snk_rgb=0, snk_fc=0; CTRL=0, BASE=0; FSM=IDLE; FIFO empty.
//  Registers: writes take effect next cycle. FSM copies enable and BASE only in IDLE (frame boundary).
//   Clearing enable mid-frame therefore stops scan-out after pixel (H_DISPLAY-1, V_DISPLAY-1).
//  FSM IDLE: if enable_q -> latch base into addr_cnt, hc=vc=0, go ISSUE.
//  FSM ISSUE: if FIFO not full (count < FIFO_DEPTH) -> drive addr=addr_cnt, ce_n=oe_n=0, be_n=0, go WAIT.
//  FSM WAIT: hold for READ_WAIT cycles total; on the last cycle capture dq, push {hc,vc,frame_start,pixel}.
//   Then release ce_n/oe_n, advance counters, go ISSUE (or IDLE after the last pixel).
//  One read outstanding max; a push never overflows because the room check is made at ISSUE with no pop dependency.
//  Address: linear counter addr_cnt+1 per pixel, no multiply; wraps modulo 2^SRAM_AW (base near top wraps to 0).
//  Counters: hc 0..H_DISPLAY-1 then 0 and vc++; after (H-1,V-1) return to IDLE. Next frame starts from IDLE (re-latch).
//  Output: FIFO head drives snk_*; pop on snk_vld&&snk_rdy; push and pop in same cycle when full are both legal.
//   snk_vld deasserted only when empty; snk_* stable while snk_vld&&!snk_rdy.
//  Throughput: one pixel per READ_WAIT+1 cycles when unstalled; latency enable -> first snk_vld = READ_WAIT+3 cycles.
//  Reset mid-read: all state returns to reset values immediately; the partial read is discarded.
// CONFIGURATION
//  FB_READER_TEST_PATTERN_EN defined: CTRL[1]=pattern select (reset 0), latched in IDLE with enable.
//   When 1, no SRAM access (ce_n stays 1); the ISSUE->WAIT path is replaced by a one-cycle push of a pattern pixel.
//   Pattern: 8 vertical bars, width H_DISPLAY/8, bar k = {R=k[2],G=k[1],B=k[0]} each replicated to full channel width.
//  FB_READER_TEST_PATTERN_EN undefined: CTRL[1] ignored, reads as SRAM only.
// STRUCTURE
//  Shared package/header (vga.svh): vga_fc_t, `H_SIZE, `V_SIZE; add reader register-offset localparams CTRL=0, BASE=1.
//  Sub-module: video_fb_reader_fifo (sync FIFO, FIFO_DEPTH x (RGB_SIZE+$bits(vga_fc_t)), full/empty/count).
// TESTING
//  1. BASE=0x100, enable=1, snk_rdy=1, SRAM model returns addr[11:0] -> first out (0,0) rgb=0x100 frame_start=1; next (1,0) rgb=0x101.
//  2. snk_rdy=0 for 50 cycles -> exactly FIFO_DEPTH reads issued, ce_n stays 1 after; no pixel lost or repeated on release.
//  3. BASE=2^18-10 -> 11th pixel reads address 0; full frame = 307200 pixels, last at (639,479).
//  4. Clear enable at pixel (100,200) -> frame completes to (639,479), then ce_n=1, snk_vld=0 forever.
//  5. Assert rst during WAIT -> ce_n=oe_n=1 and snk_vld=0 while rst is high; on release re-enable restarts at (0,0).
//  6. With FB_READER_TEST_PATTERN_EN, CTRL=0x3 -> pixel (80,0)=bar1=0x00F; pixel (560,0)=bar7=0xFFF; ce_n never 0.

Source files
------------

// File: rtl/video_fb_reader_pkg.sv
// Shared types for the frame-buffer reader: pixel coordinate bundle,
// register offsets and FSM state encoding.
package video_fb_reader_pkg;

  localparam int H_SIZE = 640;
  localparam int V_SIZE = 480;
  localparam int FC_HW  = 10;
  localparam int FC_VW  = 10;

  localparam logic CTRL = 1'b0;
  localparam logic BASE = 1'b1;

  typedef struct packed {
    logic [FC_HW-1:0] hc;
    logic [FC_VW-1:0] vc;
    logic             frame_start;
  } vga_fc_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

endpackage

// File: rtl/video_fb_reader_fifo.sv
// Small synchronous skid FIFO holding {vga_fc_t, rgb} entries.
// Storage is reset so the head reads as zero while empty.
module video_fb_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/video_fb_reader_core.sv
// Raster-order SRAM frame-buffer reader feeding the video pixel chain.
// Optional FB_READER_TEST_PATTERN_EN adds an SRAM-free colour-bar source.
module video_fb_reader_core
  import video_fb_reader_pkg::*;
#(
  parameter int RGB_SIZE   = 12,
  parameter int SRAM_AW    = 18,
  parameter int SRAM_DW    = 16,
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int READ_WAIT  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 avs_address,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [SRAM_DW/8-1:0] sram_be_n,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic                 sram_dq_en,
  input  logic [SRAM_DW-1:0]   sram_dq_read,
  output vga_fc_t              snk_fc,
  output logic                 snk_vld,
  output logic [RGB_SIZE-1:0]  snk_rgb,
  input  logic                 snk_rdy
);

  localparam int FW  = RGB_SIZE + $bits(vga_fc_t);
  localparam int WCW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam int CW  = RGB_SIZE / 3;

  state_t                  r_state;
  logic                    r_en;
  logic [SRAM_AW-1:0]      r_base;
  logic [SRAM_AW-1:0]      r_addr_cnt;
  logic [FC_HW-1:0]        r_hc;
  logic [FC_VW-1:0]        r_vc;
  logic [WCW-1:0]          r_wcnt;
  logic                    r_ce_n;
  logic                    r_oe_n;
  logic [SRAM_DW/8-1:0]    r_be_n;
  logic [SRAM_AW-1:0]      r_addr;

  logic                    w_pat_mode;
  logic [RGB_SIZE-1:0]     w_bar_rgb;
  logic                    w_wait_done;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                    w_hc_last;
  logic                    w_last;
  logic [RGB_SIZE-1:0]     w_pix;
  vga_fc_t                 w_fc;
  logic [FW-1:0]           w_head;
  logic                    w_unused;

`ifdef FB_READER_TEST_PATTERN_EN
  logic                    r_pat_sel;
  logic                    r_pat;
  logic [FC_HW-1:0]        w_bar;

  assign w_pat_mode = r_pat;
  assign w_bar      = r_hc / FC_HW'(H_DISPLAY / 8);
  assign w_bar_rgb  = RGB_SIZE'({{CW{w_bar[2]}}, {CW{w_bar[1]}},
                                 {CW{w_bar[0]}}});
  assign w_unused   = ^{avs_writedata[31:SRAM_AW], w_count,
                        sram_dq_read[SRAM_DW-1:RGB_SIZE],
                        w_bar[FC_HW-1:3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat_sel <= 1'b0;
      r_pat     <= 1'b0;
    end else begin
      if (avs_write && avs_address == CTRL) r_pat_sel <= avs_writedata[1];
      if (r_state == S_IDLE && r_en) r_pat <= r_pat_sel;
    end
  end
`else
  assign w_pat_mode = 1'b0;
  assign w_bar_rgb  = '0;
  assign w_unused   = ^{avs_writedata[31:SRAM_AW], w_count,
                        sram_dq_read[SRAM_DW-1:RGB_SIZE]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_base <= '0;
    end else if (avs_write) begin
      if (avs_address == CTRL) r_en   <= avs_writedata[0];
      else                     r_base <= avs_writedata[SRAM_AW-1:0];
    end
  end

  assign w_hc_last   = (r_hc == FC_HW'(H_DISPLAY - 1));
  assign w_last      = w_hc_last && (r_vc == FC_VW'(V_DISPLAY - 1));
  assign w_wait_done = (r_state == S_WAIT) &&
                       (r_wcnt == WCW'(READ_WAIT - 1));
  assign w_push      = w_wait_done ||
                       (r_state == S_ISSUE && w_pat_mode && !w_full);
  assign w_pix       = w_pat_mode ? w_bar_rgb
                                  : sram_dq_read[RGB_SIZE-1:0];

  assign w_fc.hc          = r_hc;
  assign w_fc.vc          = r_vc;
  assign w_fc.frame_start = (r_hc == '0) && (r_vc == '0);

  // Counters advance on every push; the room check lives in ISSUE only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr_cnt <= '0;
      r_hc       <= '0;
      r_vc       <= '0;
      r_wcnt     <= '0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_be_n     <= '1;
      r_addr     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_en) begin
            r_addr_cnt <= r_base;
            r_hc       <= '0;
            r_vc       <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!w_full && !w_pat_mode) begin
            r_addr  <= r_addr_cnt;
            r_ce_n  <= 1'b0;
            r_oe_n  <= 1'b0;
            r_be_n  <= '0;
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_wait_done) begin
            r_ce_n <= 1'b1;
            r_oe_n <= 1'b1;
            r_be_n <= '1;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_push) begin
        r_addr_cnt <= r_addr_cnt + 1'b1;
        r_hc       <= w_hc_last ? '0 : r_hc + 1'b1;
        r_vc       <= w_hc_last ? r_vc + 1'b1 : r_vc;
        r_state    <= w_last ? S_IDLE : S_ISSUE;
      end
    end
  end

  assign w_pop = snk_vld && snk_rdy;

  video_fb_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_fc, w_pix}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign snk_vld    = !w_empty;
  assign snk_fc     = w_head[FW-1:RGB_SIZE];
  assign snk_rgb    = w_head[RGB_SIZE-1:0];
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = 1'b1;
  assign sram_be_n  = r_be_n;
  assign sram_addr  = r_addr;
  assign sram_dq_en = 1'b0;

endmodule

// File: tb/tb_video_fb_reader_core.sv
// Bench for video_fb_reader_core on a reduced 32x6 raster.
// Reference model derives every pixel from its raster index.
module tb_video_fb_reader_core;
  import video_fb_reader_pkg::*;

  localparam int H     = 32;
  localparam int V     = 6;
  localparam int RW    = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int RGB   = 12;
  localparam int NPIX  = H * V;
  localparam int BUDGET = NPIX * (RW + 1) * 4 + 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [DW/8-1:0]   sram_be_n;
  logic [AW-1:0]     sram_addr;
  logic              sram_dq_en;
  logic [DW-1:0]     sram_dq_read;
  vga_fc_t           snk_fc;
  logic              snk_vld;
  logic [RGB-1:0]    snk_rgb;
  logic              snk_rdy;

  video_fb_reader_core #(
    .RGB_SIZE   (RGB),
    .SRAM_AW    (AW),
    .SRAM_DW    (DW),
    .H_DISPLAY  (H),
    .V_DISPLAY  (V),
    .READ_WAIT  (RW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .sram_ce_n     (sram_ce_n),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .sram_be_n     (sram_be_n),
    .sram_addr     (sram_addr),
    .sram_dq_en    (sram_dq_en),
    .sram_dq_read  (sram_dq_read),
    .snk_fc        (snk_fc),
    .snk_vld       (snk_vld),
    .snk_rgb       (snk_rgb),
    .snk_rdy       (snk_rdy)
  );

  always #5 clk = ~clk;

  // SRAM content: low 12 bits mirror the address, upper nibble is junk.
  assign sram_dq_read = {4'hA, sram_addr[11:0]};

  int n_tests = 0;
  int n_fail  = 0;

  int            m_n;
  bit            m_active;
  logic [AW-1:0] m_base;
  bit            m_pat;

  logic [RGB-1:0] rgb_log [NPIX];
  vga_fc_t        fc_log  [NPIX];
  vga_fc_t        last_fc;
  int             reads;
  bit             ce_seen0;
  bit             prev_ce;
  bit             prev_stall;
  logic [32:0]    prev_out;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [RGB-1:0] exp_rgb(int n);
    logic [2:0]    k;
    logic [AW-1:0] a;
    if (m_pat) begin
      k = 3'((n % H) / (H / 8));
      return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    end
    a = m_base + AW'(n);
    return a[11:0];
  endfunction

  always @(negedge clk) begin
    vga_fc_t efc;
    if (rst) begin
      prev_ce    = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (prev_ce && !sram_ce_n) reads++;
      if (!sram_ce_n) ce_seen0 = 1'b1;
      prev_ce = sram_ce_n;
      if (prev_stall)
        check("hold", {snk_vld, snk_fc, snk_rgb}, {1'b1, prev_out});
      if (snk_vld && snk_rdy) begin
        n_tests++;
        if (!m_active) begin
          n_fail++;
          $display("FAIL extra_pixel: got hc=%0d vc=%0d expected none",
                   snk_fc.hc, snk_fc.vc);
        end else begin
          efc.hc          = FC_HW'(m_n % H);
          efc.vc          = FC_VW'(m_n / H);
          efc.frame_start = (m_n == 0);
          if ({snk_fc, snk_rgb} !== {efc, exp_rgb(m_n)}) begin
            n_fail++;
            $display("FAIL pixel%0d: got %0h expected %0h", m_n,
                     {snk_fc, snk_rgb}, {efc, exp_rgb(m_n)});
          end
          rgb_log[m_n] = snk_rgb;
          fc_log[m_n]  = snk_fc;
          last_fc      = snk_fc;
          m_n++;
          if (m_n == NPIX) m_active = 1'b0;
        end
      end
      prev_stall = snk_vld && !snk_rdy;
      prev_out   = {snk_fc, snk_rgb};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic a, logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic start_frame(logic [AW-1:0] base, bit pat);
    m_base   = base;
    m_pat    = pat;
    m_n      = 0;
    m_active = 1'b1;
    wr(BASE, 32'(base));
    wr(CTRL, pat ? 32'h3 : 32'h1);
  endtask

  task automatic wait_done(string nm, bit rnd);
    int c = 0;
    while (m_active && c < BUDGET) begin
      if (rnd) snk_rdy = ($urandom_range(0, 3) != 0);
      tick();
      c++;
    end
    snk_rdy = 1'b1;
    check(nm, 64'(m_active), 64'd0);
  endtask

  task automatic check_idle(string nm);
    int bad = 0;
    repeat (30) begin
      tick();
      if (!sram_ce_n || snk_vld) bad++;
    end
    check(nm, 64'(bad), 64'd0);
  endtask

  function automatic logic [20:0] fc(int h, int v, bit fs);
    return {FC_HW'(h), FC_VW'(v), fs};
  endfunction

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int c;
    rst = 1'b1; avs_address = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; snk_rdy = 1'b1;
    m_n = 0; m_active = 1'b0; m_base = '0; m_pat = 1'b0;
    reads = 0; ce_seen0 = 1'b0;
    repeat (3) tick();
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_be_n", sram_be_n, 2'b11);
    check("rst_addr", sram_addr, 0);
    check("rst_vld", snk_vld, 0);
    check("rst_rgb", snk_rgb, 0);
    check("rst_fc", snk_fc, 0);
    check("we_n", sram_we_n, 1);
    check("dq_en", sram_dq_en, 0);
    rst = 1'b0;
    check_idle("idle_after_rst");

    // Base 0x100 with latency measurement, enable cleared mid-frame.
    start_frame(18'h100, 1'b0);
    lat = 1;
    while (!snk_vld && lat < 50) begin tick(); lat++; end
    check("latency", 64'(lat), 64'(RW + 3));
    wr(CTRL, 32'h0);
    wait_done("t1_done", 1'b0);
    check("t1_rgb0", rgb_log[0], 12'h100);
    check("t1_rgb1", rgb_log[1], 12'h101);
    check("t1_fc0", fc_log[0], fc(0, 0, 1));
    check("t1_fc1", fc_log[1], fc(1, 0, 0));
    check("t1_last", last_fc, fc(H - 1, V - 1, 0));
    check_idle("t1_idle");

    // Downstream stalled from the start: FIFO fills, then reads stop.
    snk_rdy = 1'b0;
    reads = 0;
    start_frame(18'h200, 1'b0);
    wr(CTRL, 32'h0);
    repeat (50) tick();
    check("stall_reads", 64'(reads), 64'(DEPTH));
    check("stall_ce", sram_ce_n, 1);
    check("stall_vld", snk_vld, 1);
    wait_done("t2_done", 1'b1);
    check_idle("t2_idle");

    // Base near the top of SRAM wraps to address 0.
    start_frame(18'h3FFF6, 1'b0);
    wr(CTRL, 32'h0);
    wait_done("t3_done", 1'b1);
    check("wrap_9", rgb_log[9], 12'hFFF);
    check("wrap_10", rgb_log[10], 12'h000);
    check("t3_last", last_fc, fc(H - 1, V - 1, 0));

    // Enable cleared deep inside the frame: frame still completes.
    start_frame(18'h1234, 1'b0);
    c = 0;
    while (m_n < 2 * H + 5 && c < BUDGET) begin tick(); c++; end
    check("t4_reach", 64'(m_n >= 2 * H + 5), 64'd1);
    wr(CTRL, 32'h0);
    wait_done("t4_done", 1'b0);
    check("t4_last", last_fc, fc(H - 1, V - 1, 0));
    check_idle("t4_idle");

    // Reset while a read is in flight.
    start_frame(18'h40, 1'b0);
    c = 0;
    while (sram_ce_n && c < 50) begin tick(); c++; end
    check("t5_read_seen", sram_ce_n, 0);
    rst = 1'b1;
    m_active = 1'b0;
    #1;
    check("t5_ce_n", sram_ce_n, 1);
    check("t5_oe_n", sram_oe_n, 1);
    check("t5_vld", snk_vld, 0);
    c = 0;
    repeat (3) begin
      tick();
      if (!sram_ce_n || !sram_oe_n || snk_vld) c++;
    end
    check("t5_hold", 64'(c), 64'd0);
    rst = 1'b0;
    check_idle("t5_no_reenable");
    start_frame(18'h40, 1'b0);
    wr(CTRL, 32'h0);
    wait_done("t5_done", 1'b0);
    check("t5_fc0", fc_log[0], fc(0, 0, 1));
    check("t5_rgb0", rgb_log[0], 12'h040);

`ifdef FB_READER_TEST_PATTERN_EN
    ce_seen0 = 1'b0;
    start_frame(18'h0, 1'b1);
    wr(CTRL, 32'h0);
    wait_done("t6_done", 1'b1);
    check("bar1", rgb_log[H / 8], 12'h00F);
    check("bar7", rgb_log[7 * H / 8], 12'hFFF);
    check("pat_no_sram", 64'(ce_seen0), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
